// File: rtl/register_file_if.sv
// Register file access bundle: one write port, two registered read ports.
// Master drives requests, slave returns read data and valid strobes.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  modport master (
    output we, waddr, wdata,
    output re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  we, waddr, wdata,
    input  re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/register_file.sv
// Flop-based architectural register file, 1W/2R, registered reads
// with write-first bypass and optional hardwired zero entry.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic            clk,
  input logic            rst_n,
  register_file_if.slave bus
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [N];
  logic              wr_en;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              rv_a;
  logic              rv_b;

  // Zero entry wins over the bypass, so a write to 0 never leaks out.
  function automatic logic [DATA_W-1:0] pick(
    input logic [ADDR_W-1:0] a,
    input logic              w,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] st
  );
    if (ZERO_REG != 0 && a == '0)
      return '0;
    else if (w && wa == a)
      return wd;
    else
      return st;
  endfunction

  always_comb begin
    wr_en = bus.we && !(ZERO_REG != 0 && bus.waddr == '0);
    nxt_a = pick(bus.raddr_a, bus.we, bus.waddr,
                 bus.wdata, mem[bus.raddr_a]);
    nxt_b = pick(bus.raddr_b, bus.we, bus.waddr,
                 bus.wdata, mem[bus.raddr_b]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rv_a <= 1'b0;
      rd_b <= '0;
      rv_b <= 1'b0;
    end else begin
      rv_a <= bus.re_a;
      rv_b <= bus.re_b;
      if (bus.re_a)
        rd_a <= nxt_a;
      if (bus.re_b)
        rd_b <= nxt_b;
    end
  end

  assign bus.rdata_a  = rd_a;
  assign bus.rvalid_a = rv_a;
  assign bus.rdata_b  = rd_b;
  assign bus.rvalid_b = rv_b;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read results are
// queued when requests are driven and popped after each clock.
module tb_register_file;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  register_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  register_file #(
    .DATA_W(32),
    .ADDR_W(5),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] m[32];
  logic [31:0] ha;
  logic [31:0] hb;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_rd(
    input logic [4:0] a, input logic w,
    input logic [4:0] wa, input logic [31:0] wd
  );
    if (a == 5'd0) return 32'h0;
    if (w && wa == a) return wd;
    return m[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    ha = 32'h0;
    hb = 32'h0;
    qa.delete();
    qb.delete();
  endtask

  task automatic step(
    input logic w, input logic [4:0] wa,
    input logic [31:0] wd,
    input logic ea, input logic [4:0] ra,
    input logic eb, input logic [4:0] rb
  );
    exp_t xa;
    exp_t xb;
    bus.we      = w;
    bus.waddr   = wa;
    bus.wdata   = wd;
    bus.re_a    = ea;
    bus.raddr_a = ra;
    bus.re_b    = eb;
    bus.raddr_b = rb;
    if (ea) ha = ref_rd(ra, w, wa, wd);
    if (eb) hb = ref_rd(rb, w, wa, wd);
    qa.push_back('{v: ea, d: ha});
    qb.push_back('{v: eb, d: hb});
    if (w && wa != 5'd0) m[wa] = wd;
    @(posedge clk);
    #1;
    if (qa.size() == 0 || qb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      xa = qa.pop_front();
      xb = qb.pop_front();
      chk("rv_a", {31'd0, bus.rvalid_a}, {31'd0, xa.v});
      chk("rd_a", bus.rdata_a, xa.d);
      chk("rv_b", {31'd0, bus.rvalid_b}, {31'd0, xb.v});
      chk("rd_b", bus.rdata_b, xb.d);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.re_a    = 1'b0;
    bus.raddr_a = '0;
    bus.re_b    = 1'b0;
    bus.raddr_b = '0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rv_a", {31'd0, bus.rvalid_a}, 32'd0);
    chk("rst_rd_a", bus.rdata_a, 32'd0);
    chk("rst_rv_b", {31'd0, bus.rvalid_b}, 32'd0);
    chk("rst_rd_b", bus.rdata_b, 32'd0);
    rst_n = 1'b1;

    // reads of untouched entries after reset
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd7);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd1);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd31);

    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    chk("wr_rd5", bus.rdata_a, 32'hDEADBEEF);

    step(1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b1, 5'd9, 32'h22222222, 1'b1, 5'd9, 1'b1, 5'd9);
    chk("byp_a", bus.rdata_a, 32'h22222222);
    chk("byp_b", bus.rdata_b, 32'h22222222);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    chk("byp_later", bus.rdata_a, 32'h22222222);

    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0);
    chk("zero_a", bus.rdata_a, 32'h0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd0);
    chk("zero_b", bus.rdata_b, 32'h0);

    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0);
      chk("hold_rv", {31'd0, bus.rvalid_a}, 32'd0);
      chk("hold_rd", bus.rdata_a, 32'hDEADBEEF);
    end
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    chk("new5", bus.rdata_b, 32'h1234);

    // back-to-back random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    chk("pre_rst_rd3", bus.rdata_a, 32'hA5A5A5A5);
    bus.re_a    = 1'b1;
    bus.raddr_a = 5'd3;
    bus.we      = 1'b1;
    bus.waddr   = 5'd4;
    bus.wdata   = 32'hCAFEF00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rv_a", {31'd0, bus.rvalid_a}, 32'd0);
    chk("arst_rd_a", bus.rdata_a, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_rv", {31'd0, bus.rvalid_a}, 32'd0);
    model_clear();
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
    chk("post_rst3", bus.rdata_a, 32'h0);
    chk("post_rst4", bus.rdata_b, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
